idma_legalizer_r_axi_w_obi: RTL
===============================

// Module: idma_legalizer_r_axi_w_obi
// PURPOSE
// - Mirror of the OBI-read/AXI-write legalizer: splits a generic 1D iDMA transfer into legal AXI4 read bursts (AR) and OBI word writes.
// - Sits between the 1D frontend/midend and the r_axi/w_obi transport backend.
// - Read side is page-split; write side is serialised into one OBI request per bus word, with byte enables.
// - R and W machines always run decoupled.
// PARAMETERS
// - DataWidth  32  bus width in bits; StrbWidth=DataWidth/8, OffW=$clog2(StrbWidth)
// - AddrWidth  32  byte-address width
// - LenWidth   32  transfer-length width in bytes
// - IdWidth     2  AXI ID width
// PORTS
// - clk_i         in   1           clock
// - rst_ni        in   1           asynchronous reset, active low
// - req_len_i     in   LenWidth    transfer length in bytes
// - req_src_i     in   AddrWidth   source byte address
// - req_dst_i     in   AddrWidth   destination byte address
// - req_id_i      in   IdWidth     AXI ID for AR
// - valid_i       in   1           request valid
// - ready_o       out  1           request ready
// - ar_addr_o     out  AddrWidth   AR address, word-aligned (low OffW bits zero)
// - ar_len_o      out  8           AR beats-1
// - ar_id_o       out  IdWidth     AR ID
// - ar_offset_o   out  OffW        first-beat byte offset, to the read datapath
// - ar_valid_o    out  1           AR valid
// - ar_ready_i    in   1           AR ready
// - w_addr_o      out  AddrWidth   OBI write address, word-aligned
// - w_be_o        out  StrbWidth   OBI byte enables
// - w_last_o      out  1           final word of the 1D transfer
// - w_valid_o     out  1           OBI req
// - w_ready_i     in   1           OBI gnt
// - flush_i       in   1           stall emission; no state advance
// - kill_i        in   1           abort active transfer
// - r_busy_o      out  1           read machine holds work
// - w_busy_o      out  1           write machine holds work
// BEHAVIOUR
// - State: r {addr,rem,busy}, w {addr,rem,busy}, id. On reset all are 0, so r/w_busy_o=0, ar/w_valid_o=0, and ready_o=1 unless flush_i is high.
// - ready_o = !r_busy & !w_busy & !flush_i (combinational).
// - Accept on valid_i&ready_o: load both machines. busy = (len!=0); a zero-length request is consumed with no emission.
// - Page: PageSize = min(4096, 256*StrbWidth).
// - Read bytes per burst: rb = min(r.rem, PageSize - r.addr[log2(PageSize)-1:0]).
// - ar_len_o = (rb + r.addr[OffW-1:0] - 1) >> OffW.
// - ar_valid_o = r_busy & !flush_i. On ar_ready_i: addr += rb, rem -= rb, busy clears when rem==rb.
// - Write bytes per word: wb = min(w.rem, StrbWidth - w.addr[OffW-1:0]).
// - w_be_o bits [off, off+wb-1] set, all others 0. w_last_o = (w.rem==wb).
// - w_valid_o = w_busy & !flush_i. On w_ready_i: addr += wb, rem -= wb.
// - Outputs hold stable while valid & !ready (AXI/OBI stability rule); 0-cycle latency from state to outputs.
// - Arithmetic: rem/addr sums computed at LenWidth+1 and AddrWidth; no address wrap handling beyond natural AddrWidth overflow.
// - kill_i: same cycle, clear both machines (busy=0). Outputs are not gated in that cycle. A new request may be accepted the next cycle. kill_i has priority over a handshake.
// - flush_i: valids forced low, no state change, ready_o low.
// - Simultaneous: the R and W handshakes in one cycle are independent. Acceptance only happens when idle, so there is no conflict with it.
// CONFIGURATION
// - IDMA_LEGALIZER_W_OBI_BEAT_CNT_EN defined: adds output w_beats_o [LenWidth], the count of OBI words issued for the current transfer.
//   - Reset 0, cleared on accept, +1 per w handshake, holds after the last word.
// - Macro undefined: w_beats_o and its counter do not exist; all other behaviour is identical.
// TESTING (DataWidth=32)
// - len=10 src=0x0 dst=0x2 -> AR addr0 len2 off0. OBI words: 0x0 be1100; 0x4 be1111; 0x8 be1111 last.
// - len=8 src=0x3FC dst=0x0 -> AR 0x3FC len0, then AR 0x400 len0 (1KiB page). OBI 0x0, 0x4 be1111; last on 0x4.
// - len=0 -> accepted in 1 cycle; no AR, no OBI; busy stays 0.
// - ar_ready_i low 5 cycles mid-transfer -> ar_* held stable; w side keeps issuing words.
// - kill_i during 3rd OBI word of len=64 -> next cycle busy=0, valids=0, ready_o=1.
// - flush_i high 3 cycles -> valids and ready_o low; transfer resumes unchanged after; beat count (if enabled) correct.

Source files
------------

// File: rtl/idma_legalizer_r_axi_w_obi.sv
// Splits a 1D iDMA transfer into page-bounded AXI4 read bursts and per-word OBI writes.
// Optional: define IDMA_LEGALIZER_W_OBI_BEAT_CNT_EN to add the w_beats_o issued-word counter.
module idma_legalizer_r_axi_w_obi #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned LenWidth  = 32,
  parameter int unsigned IdWidth   = 2,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned OffW      = $clog2(StrbWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [LenWidth-1:0]  req_len_i,
  input  logic [AddrWidth-1:0] req_src_i,
  input  logic [AddrWidth-1:0] req_dst_i,
  input  logic [IdWidth-1:0]   req_id_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [AddrWidth-1:0] ar_addr_o,
  output logic [7:0]           ar_len_o,
  output logic [IdWidth-1:0]   ar_id_o,
  output logic [OffW-1:0]      ar_offset_o,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  output logic [AddrWidth-1:0] w_addr_o,
  output logic [StrbWidth-1:0] w_be_o,
  output logic                 w_last_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
`ifdef IDMA_LEGALIZER_W_OBI_BEAT_CNT_EN
  output logic [LenWidth-1:0]  w_beats_o,
`endif
  input  logic                 flush_i,
  input  logic                 kill_i,
  output logic                 r_busy_o,
  output logic                 w_busy_o
);

  localparam int unsigned PageSize = (256 * StrbWidth < 4096) ? 256 * StrbWidth : 4096;
  localparam int unsigned PageW    = $clog2(PageSize);
  localparam int unsigned XW       = LenWidth + 1;

  logic [AddrWidth-1:0] r_addr, w_addr;
  logic [LenWidth-1:0]  r_rem, w_rem;
  logic                 r_busy, w_busy;
  logic [IdWidth-1:0]   id;

  logic [XW-1:0] r_rem_x, r_page_left, rb;
  logic [XW-1:0] w_rem_x, w_word_left, w_off_x, wb;
  logic          accept, ar_hs, w_hs;

  assign ready_o  = !r_busy && !w_busy && !flush_i;
  assign accept   = valid_i && ready_o;
  assign r_busy_o = r_busy;
  assign w_busy_o = w_busy;

  assign ar_valid_o  = r_busy && !flush_i;
  assign ar_addr_o   = {r_addr[AddrWidth-1:OffW], OffW'(0)};
  assign ar_id_o     = id;
  assign ar_offset_o = r_addr[OffW-1:0];
  assign ar_hs       = ar_valid_o && ar_ready_i;

  assign w_valid_o = w_busy && !flush_i;
  assign w_addr_o  = {w_addr[AddrWidth-1:OffW], OffW'(0)};
  assign w_hs      = w_valid_o && w_ready_i;

  // Burst never crosses a page; beat count includes the leading misalignment.
  always_comb begin
    r_rem_x     = {1'b0, r_rem};
    r_page_left = XW'(PageSize) - XW'(r_addr[PageW-1:0]);
    rb          = (r_rem_x < r_page_left) ? r_rem_x : r_page_left;
    ar_len_o    = 8'((rb + XW'(r_addr[OffW-1:0]) - XW'(1)) >> OffW);
  end

  always_comb begin
    w_rem_x     = {1'b0, w_rem};
    w_off_x     = XW'(w_addr[OffW-1:0]);
    w_word_left = XW'(StrbWidth) - w_off_x;
    wb          = (w_rem_x < w_word_left) ? w_rem_x : w_word_left;
    w_last_o    = (w_rem_x == wb);
    w_be_o      = '0;
    for (int i = 0; i < StrbWidth; i++) begin
      w_be_o[i] = (XW'(i) >= w_off_x) && (XW'(i) < w_off_x + wb);
    end
  end

  // Acceptance only happens when idle, so it can never collide with an abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr <= '0;
      w_addr <= '0;
      r_rem  <= '0;
      w_rem  <= '0;
      r_busy <= 1'b0;
      w_busy <= 1'b0;
      id     <= '0;
    end else if (accept) begin
      r_addr <= req_src_i;
      w_addr <= req_dst_i;
      r_rem  <= req_len_i;
      w_rem  <= req_len_i;
      r_busy <= (req_len_i != '0);
      w_busy <= (req_len_i != '0);
      id     <= req_id_i;
    end else if (kill_i) begin
      r_busy <= 1'b0;
      w_busy <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_addr <= r_addr + AddrWidth'(rb);
        r_rem  <= r_rem - LenWidth'(rb);
        if (r_rem_x == rb) r_busy <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= w_addr + AddrWidth'(wb);
        w_rem  <= w_rem - LenWidth'(wb);
        if (w_last_o) w_busy <= 1'b0;
      end
    end
  end

`ifdef IDMA_LEGALIZER_W_OBI_BEAT_CNT_EN
  logic [LenWidth-1:0] w_beats;
  assign w_beats_o = w_beats;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_beats <= '0;
    end else if (accept) begin
      w_beats <= '0;
    end else if (!kill_i && w_hs) begin
      w_beats <= w_beats + LenWidth'(1);
    end
  end
`endif

endmodule
